// File: rtl/mult_pipe_hs.sv
// Pipelined A_W x B_W integer multiplier with valid/ready backpressure, per-transaction signed mode and tag.
// Optional: define MULT_PIPE_ACC_EN to add in_acc, which adds the product onto the last emitted result.
module mult_pipe_hs #(
    parameter  int A_W    = 32,
    parameter  int B_W    = 48,
    parameter  int STAGES = 2,
    parameter  int TAG_W  = 8,
    localparam int P_W    = A_W + B_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [A_W-1:0]   dataa,
    input  logic [B_W-1:0]   datab,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   dataout,
    output logic [TAG_W-1:0] out_tag
`ifdef MULT_PIPE_ACC_EN
    ,
    input  logic             in_acc
`endif
);

    typedef struct packed {
        logic             vld;
        logic             sgn;
        logic             acc;
        logic [A_W-1:0]   a;
        logic [B_W-1:0]   b;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic             adv;
    logic             acc_in;
    stage_t           in_ent;
    stage_t           fin_src;
    logic [P_W-1:0]   ext_a;
    logic [P_W-1:0]   ext_b;
    logic [P_W-1:0]   prod;
    logic [P_W-1:0]   dataout_d;
    logic             out_valid_q;
    logic [P_W-1:0]   dataout_q;
    logic [TAG_W-1:0] out_tag_q;

`ifdef MULT_PIPE_ACC_EN
    assign acc_in = in_acc;
`else
    assign acc_in = 1'b0;
`endif

    // The whole pipe moves together; a held result freezes every stage behind it.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        in_ent     = '0;
        in_ent.vld = in_valid & adv;
        in_ent.sgn = in_signed;
        in_ent.acc = acc_in;
        in_ent.a   = dataa;
        in_ent.b   = datab;
        in_ent.tag = in_tag;
    end

    // Stages 1..STAGES-1 carry operands; stage STAGES is the output register itself.
    if (STAGES > 1) begin : g_pipe
        stage_t pipe_q [1:STAGES-1];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int s = 1; s < STAGES; s++) pipe_q[s] <= '0;
            end else if (adv) begin
                pipe_q[1] <= in_ent;
                for (int s = 2; s < STAGES; s++) pipe_q[s] <= pipe_q[s-1];
            end
        end

        assign fin_src = pipe_q[STAGES-1];
    end else begin : g_direct
        assign fin_src = in_ent;
    end

    // Extending to P_W first makes the truncated unsigned product exact for both modes.
    always_comb begin
        ext_a     = {{B_W{fin_src.sgn & fin_src.a[A_W-1]}}, fin_src.a};
        ext_b     = {{A_W{fin_src.sgn & fin_src.b[B_W-1]}}, fin_src.b};
        prod      = ext_a * ext_b;
        dataout_d = fin_src.acc ? (prod + dataout_q) : prod;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            dataout_q   <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= fin_src.vld;
            if (fin_src.vld) begin
                dataout_q <= dataout_d;
                out_tag_q <= fin_src.tag;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;
    assign out_tag   = out_tag_q;

endmodule
